// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
// APB4 completer holding a word-addressed register file of DEPTH 32-bit
// words. Writes honour per-byte strobes. Every transfer can be stretched by
// WAIT_CYCLES wait states. Indices at or above DEPTH complete with PSLVERR.
//
// Ports:
//   PCLK     clock; all state changes on its rising edge
//   PRESETn  asynchronous active-low reset
//   PSEL     completer select
//   PENABLE  access-phase indicator
//   PWRITE   1 = write, 0 = read
//   PADDR    word index (not a byte address)
//   PWDATA   write data
//   PSTRB    byte-lane write enables; PSTRB[i] gates PWDATA[8i+7:8i]
//   PRDATA   read data, registered, valid while PREADY=1 on a read
//   PREADY   registered; high for exactly one cycle per completed transfer
//   PSLVERR  registered error response, valid only while PREADY=1

module apb_slave_regfile #(
   parameter int ADDR_WIDTH  = 5,
   parameter int DEPTH       = 24,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]           PWDATA,
   input  logic [3:0]            PSTRB,
   output logic [31:0]           PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   logic [1:0]  state;
   logic [3:0]  wait_cnt;
   logic [31:0] mem [DEPTH];

   logic        addr_valid;
   logic        setup_phase;
   logic [31:0] rsp_data;
   logic        rsp_err;

   // The index is widened by one bit so DEPTH == 2**ADDR_WIDTH still compares
   // correctly.
   assign addr_valid  = ({1'b0, PADDR} < (ADDR_WIDTH+1)'(DEPTH));
   assign setup_phase = PSEL && !PENABLE;

   // The response is formed from the current array contents at the edge that
   // raises PREADY. A write that closed on an earlier edge is therefore
   // already visible.
   always_comb begin
      rsp_err  = !addr_valid;
      rsp_data = '0;
      if (!PWRITE && addr_valid) begin
         rsp_data = mem[PADDR];
      end
   end

   // Transfer sequencing. IDLE waits for a setup phase. WAIT counts down the
   // access cycles until the last wait state. ACCESS holds PREADY high for
   // one cycle. A setup phase seen in WAIT (PENABLE dropped while still
   // selected) restarts the wait count. Losing PSEL in WAIT abandons the
   // transfer.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         PRDATA   <= '0;
         PREADY   <= 1'b0;
         PSLVERR  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (setup_phase) begin
                  if (WAIT_CYCLES == 0) begin
                     PREADY  <= 1'b1;
                     PSLVERR <= rsp_err;
                     PRDATA  <= rsp_data;
                     state   <= ST_ACCESS;
                  end else begin
                     wait_cnt <= 4'(WAIT_CYCLES);
                     state    <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!PSEL) begin
                  wait_cnt <= '0;
                  state    <= ST_IDLE;
               end else if (!PENABLE) begin
                  wait_cnt <= 4'(WAIT_CYCLES);
               end else if (wait_cnt == 4'd1) begin
                  wait_cnt <= '0;
                  PREADY   <= 1'b1;
                  PSLVERR  <= rsp_err;
                  PRDATA   <= rsp_data;
                  state    <= ST_ACCESS;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_ACCESS: begin
               PREADY  <= 1'b0;
               PSLVERR <= 1'b0;
               PRDATA  <= '0;
               state   <= ST_IDLE;
            end
            default: begin
               wait_cnt <= '0;
               PREADY   <= 1'b0;
               PSLVERR  <= 1'b0;
               PRDATA   <= '0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   // Storage is committed only at the edge closing the ACCESS cycle. An
   // aborted or reset transfer never reaches that edge, so it never
   // modifies memory. Out-of-range writes are dropped.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (state == ST_ACCESS && PWRITE && addr_valid) begin
         for (int b = 0; b < 4; b++) begin
            if (PSTRB[b]) begin
               mem[PADDR][8*b +: 8] <= PWDATA[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile
// Drives three apb_slave_regfile instances, with WAIT_CYCLES of 0, 2 and 3.
// A per-instance memory image and per-cycle expected outputs are kept in the
// bench. The driver derives them from the transfer being issued: PREADY is
// high in access cycle WAIT_CYCLES+1, the response depends on the index, and
// a write commits at the closing edge. A negedge process compares every
// output of every instance against those expectations.

module tb_apb_slave_regfile;

   localparam int DEPTH = 24;
   localparam int NDUT  = 3;

   logic        clk;
   logic        rst_n;
   logic        psel    [NDUT];
   logic        penable [NDUT];
   logic        pwrite  [NDUT];
   logic [4:0]  paddr   [NDUT];
   logic [31:0] pwdata  [NDUT];
   logic [3:0]  pstrb   [NDUT];
   logic [31:0] prdata  [NDUT];
   logic        pready  [NDUT];
   logic        pslverr [NDUT];

   logic        exp_ready [NDUT];
   logic        exp_err   [NDUT];
   logic [31:0] exp_data  [NDUT];
   logic [31:0] model_mem [NDUT][32];

   logic        last_ready [NDUT];
   logic        last_err   [NDUT];
   logic [31:0] last_data  [NDUT];

   int  check_count;
   int  pass_count;
   bit  checking;

   apb_slave_regfile #(.ADDR_WIDTH(5), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]),
      .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
      .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
   );

   apb_slave_regfile #(.ADDR_WIDTH(5), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut1 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]),
      .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
      .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
   );

   apb_slave_regfile #(.ADDR_WIDTH(5), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut2 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable[2]),
      .PWRITE(pwrite[2]), .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PSTRB(pstrb[2]),
      .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Overall time limit so a stuck run still ends with a report.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", pass_count, check_count);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int wait_of(input int k);
      case (k)
         0:       return 0;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic void check_output(input string name, input logic [31:0] act,
                                        input logic [31:0] req);
      check_count++;
      if (act === req) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at t=%0t", name, act, req, $time);
      end
   endfunction

   // Byte-mask merge: lanes whose strobe is set take the new data.
   function automatic logic [31:0] merge(input logic [31:0] old_word, input logic [31:0] data,
                                         input logic [3:0] strb);
      logic [31:0] mask;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      return (old_word & ~mask) | (data & mask);
   endfunction

   function automatic void set_exp(input int k, input logic rdy, input logic err,
                                   input logic [31:0] data);
      exp_ready[k] = rdy;
      exp_err[k]   = err;
      exp_data[k]  = data;
   endfunction

   // Every cycle, every instance must match the expected outputs.
   always @(negedge clk) begin
      if (checking) begin
         for (int k = 0; k < NDUT; k++) begin
            check_output($sformatf("dut%0d PREADY", k), {31'b0, pready[k]}, {31'b0, exp_ready[k]});
            check_output($sformatf("dut%0d PSLVERR", k), {31'b0, pslverr[k]}, {31'b0, exp_err[k]});
            check_output($sformatf("dut%0d PRDATA", k), prdata[k], exp_data[k]);
         end
      end
   end

   // Assert reset a little into the current cycle. Check that the outputs of
   // instance k clear without any clock edge, then release reset one edge
   // later.
   task automatic do_reset(input int k);
      #1;
      rst_n = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
         set_exp(d, 1'b0, 1'b0, 32'h0);
         psel[d]    = 1'b0;
         penable[d] = 1'b0;
         for (int a = 0; a < 32; a++) begin
            model_mem[d][a] = 32'h0;
         end
      end
      #1;
      check_output($sformatf("dut%0d async PREADY", k), {31'b0, pready[k]}, 32'h0);
      check_output($sformatf("dut%0d async PSLVERR", k), {31'b0, pslverr[k]}, 32'h0);
      check_output($sformatf("dut%0d async PRDATA", k), prdata[k], 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One transfer on instance k, starting at posedge+1 and returning at
   // posedge+1.
   // abort_at:   access cycle index (1-based) in which PSEL is dropped
   // restart_at: access cycle index in which PENABLE falls again (new setup)
   // reset_at:   access cycle index during which reset is asserted
   // Use -1 to disable any of these.
   task automatic apply_stimulus(input int k, input bit wr, input logic [4:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input int abort_at, input int restart_at, input int reset_at);
      int  j;
      int  wc;
      bit  restarted;
      bit  valid;
      wc    = wait_of(k);
      valid = (int'(addr) < DEPTH);
      psel[k]    = 1'b1;
      penable[k] = 1'b0;
      pwrite[k]  = wr;
      paddr[k]   = addr;
      pwdata[k]  = data;
      pstrb[k]   = strb;
      set_exp(k, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      j         = 1;
      restarted = 1'b0;
      while (1) begin
         if (j == abort_at) begin
            psel[k]    = 1'b0;
            penable[k] = 1'b0;
            set_exp(k, 1'b0, 1'b0, 32'h0);
            @(posedge clk);
            #1;
            return;
         end
         if (j == restart_at && !restarted) begin
            restarted  = 1'b1;
            penable[k] = 1'b0;
            set_exp(k, 1'b0, 1'b0, 32'h0);
            @(posedge clk);
            #1;
            j = 1;
            continue;
         end
         penable[k] = 1'b1;
         if (j == wc + 1) begin
            set_exp(k, 1'b1, !valid, (!wr && valid) ? model_mem[k][addr] : 32'h0);
         end else begin
            set_exp(k, 1'b0, 1'b0, 32'h0);
         end
         if (j == reset_at) begin
            do_reset(k);
            return;
         end
         if (j == wc + 1) begin
            #3;
            last_ready[k] = pready[k];
            last_err[k]   = pslverr[k];
            last_data[k]  = prdata[k];
            @(posedge clk);
            #1;
            if (wr && valid) begin
               model_mem[k][addr] = merge(model_mem[k][addr], data, strb);
            end
            psel[k]    = 1'b0;
            penable[k] = 1'b0;
            set_exp(k, 1'b0, 1'b0, 32'h0);
            return;
         end
         @(posedge clk);
         #1;
         j++;
      end
   endtask

   task automatic wr_xfer(input int k, input logic [4:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
      apply_stimulus(k, 1'b1, addr, data, strb, -1, -1, -1);
   endtask

   task automatic rd_xfer(input int k, input logic [4:0] addr);
      apply_stimulus(k, 1'b0, addr, 32'h0, 4'h0, -1, -1, -1);
   endtask

   initial begin
      check_count = 0;
      pass_count  = 0;
      checking    = 1'b0;
      rst_n       = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
         psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
         paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
         set_exp(d, 1'b0, 1'b0, 32'h0);
         last_ready[d] = 1'b0; last_err[d] = 1'b0; last_data[d] = '0;
         for (int a = 0; a < 32; a++) begin
            model_mem[d][a] = 32'h0;
         end
      end
      $display("[TB] start");
      @(posedge clk);
      #1;
      checking = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Zero wait states: write, then read back.
      wr_xfer(0, 5'h12, 32'hDEADBEEF, 4'hF);
      rd_xfer(0, 5'h12);
      check_output("t1 read PREADY", {31'b0, last_ready[0]}, 32'h1);
      check_output("t1 read data", last_data[0], 32'hDEADBEEF);
      check_output("t1 read PSLVERR", {31'b0, last_err[0]}, 32'h0);

      // Partial strobes update only the low half-word.
      wr_xfer(0, 5'h15, 32'hDABBCAFE, 4'hF);
      wr_xfer(0, 5'h15, 32'h11223344, 4'b0011);
      rd_xfer(0, 5'h15);
      check_output("t2 strobe merge", last_data[0], 32'hDABB3344);

      // Out-of-range index 26 errors and leaves valid storage alone.
      rd_xfer(0, 5'h1A);
      check_output("t3 oor read PSLVERR", {31'b0, last_err[0]}, 32'h1);
      check_output("t3 oor read data", last_data[0], 32'h0);
      wr_xfer(0, 5'h1A, 32'hFFFFFFFF, 4'hF);
      check_output("t3 oor write PSLVERR", {31'b0, last_err[0]}, 32'h1);
      rd_xfer(0, 5'h12);
      check_output("t3 reread data", last_data[0], 32'hDEADBEEF);
      check_output("t3 reread PSLVERR", {31'b0, last_err[0]}, 32'h0);
      rd_xfer(0, 5'd23);
      check_output("t3 last index PSLVERR", {31'b0, last_err[0]}, 32'h0);
      rd_xfer(0, 5'd24);
      check_output("t3 first bad index PSLVERR", {31'b0, last_err[0]}, 32'h1);

      // Two wait states.
      wr_xfer(1, 5'h03, 32'hCAFEF00D, 4'hF);
      rd_xfer(1, 5'h03);
      check_output("t4 read PREADY", {31'b0, last_ready[1]}, 32'h1);
      check_output("t4 read data", last_data[1], 32'hCAFEF00D);

      // Three wait states: abort after the first access cycle.
      apply_stimulus(2, 1'b1, 5'h04, 32'h12345678, 4'hF, 2, -1, -1);
      rd_xfer(2, 5'h04);
      check_output("t5 aborted write", last_data[2], 32'h0);

      // A repeated setup in WAIT restarts the wait count.
      apply_stimulus(2, 1'b1, 5'h06, 32'hA5A5A5A5, 4'hF, -1, 2, -1);
      rd_xfer(2, 5'h06);
      check_output("t5 restarted write", last_data[2], 32'hA5A5A5A5);

      // Reset during WAIT of a write to 0x05.
      wr_xfer(1, 5'h12, 32'h0BADF00D, 4'hF);
      apply_stimulus(1, 1'b1, 5'h05, 32'h55AA55AA, 4'hF, -1, -1, 1);
      rd_xfer(1, 5'h05);
      check_output("t6 lost write", last_data[1], 32'h0);
      rd_xfer(1, 5'h12);
      check_output("t6 cleared word", last_data[1], 32'h0);

      // Reset while PREADY is high on a read.
      wr_xfer(0, 5'h07, 32'h13579BDF, 4'hF);
      apply_stimulus(0, 1'b0, 5'h07, 32'h0, 4'h0, -1, -1, 1);
      rd_xfer(0, 5'h07);
      check_output("t6 cleared after access reset", last_data[0], 32'h0);

      // Randomized traffic, including idle gaps with stray PENABLE.
      for (int k = 0; k < NDUT; k++) begin
         for (int n = 0; n < 60; n++) begin
            int gap;
            int opt;
            int abort_at;
            int restart_at;
            int wc;
            wc  = wait_of(k);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
               psel[k]    = 1'b0;
               penable[k] = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
            penable[k] = 1'b0;
            opt        = int'($urandom_range(0, 7));
            abort_at   = -1;
            restart_at = -1;
            if (wc > 0 && opt == 0) abort_at   = int'($urandom_range(1, wc));
            if (wc > 0 && opt == 1) restart_at = int'($urandom_range(1, wc));
            apply_stimulus(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                           $urandom, 4'($urandom_range(0, 15)), abort_at, restart_at, -1);
         end
      end

      @(posedge clk);
      #1;
      checking = 1'b0;
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB4 completer that sits directly downstream of the APB master (APB_top) and services its PSEL/PENABLE transfers. It implements a word-addressed register file of DEPTH 32-bit words with byte strobes and a parameterised number of wait states. It returns PSLVERR for out-of-range addresses. It is the target device the APB master bench talks to.

Parameters:
ADDR_WIDTH, 5, width of PADDR; word index, not byte address
DEPTH, 24, number of implemented words; valid indices are 0..DEPTH-1; DEPTH <= 2**ADDR_WIDTH
WAIT_CYCLES, 0, wait states inserted before PREADY; legal range 0..15

Ports:
PCLK  in  1  clock, all state changes on rising edge
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  completer select
PENABLE  in  1  access-phase indicator
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_WIDTH  word index
PWDATA  in  32  write data
PSTRB  in  4  byte-lane write enables; PSTRB[i] gates PWDATA[8i+7:8i]
PRDATA  out  32  read data, valid while PREADY=1 on a read
PREADY  out  1  transfer completes in the cycle it is high
PSLVERR  out  1  error response, valid only while PREADY=1

Behaviour:
- Reset (PRESETn=0, asynchronous): state=IDLE, wait counter=0, all words=0, PRDATA=0, PREADY=0, PSLVERR=0.
- All outputs are registered.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - Setup phase (PSEL=1, PENABLE=0) at an edge:
    - WAIT_CYCLES=0: load PREADY=1, PSLVERR/PRDATA per rules below, go to ACCESS.
    - Otherwise: counter=WAIT_CYCLES, go to WAIT.
  - Anything else, including PENABLE=1 with PSEL=0, is ignored and the FSM stays in IDLE.
- WAIT:
  - Each edge with PSEL=1 and PENABLE=1 decrements the counter.
  - The edge at which the counter equals 1 loads PREADY=1 plus the response, then goes to ACCESS.
  - Result: PREADY is high in access cycle WAIT_CYCLES+1.
- ACCESS (PREADY=1 for exactly one cycle):
  - At the closing edge, perform the write if PWRITE=1 and the address is valid.
  - Only lanes with PSTRB set are updated.
  - PREADY, PSLVERR and PRDATA all go to 0, and the FSM returns to IDLE.
- Response rules, loaded together with PREADY:
  - Error: PSLVERR=1 iff PADDR >= DEPTH.
  - Read: PRDATA=mem[PADDR] if valid, else 0.
  - Write: PRDATA=0, and a write with PSLVERR=1 leaves memory unchanged.
- Read data is taken from the current array contents. A write completing on edge N is visible to a read whose response loads after edge N.
- Back-to-back transfers: a new setup phase in the cycle immediately after ACCESS is accepted from IDLE. The sustained rate is one transfer per WAIT_CYCLES+2 cycles.
- Abort: PSEL=0 while in WAIT returns the FSM to IDLE, PREADY stays 0 and no memory update occurs.
- PENABLE=0 while PSEL=1 in WAIT (protocol violation) is treated as a new setup phase and the counter reloads.
- PADDR/PWRITE/PWDATA/PSTRB are sampled at the edge where they are used. The master must hold them stable from setup through ACCESS.
- Reset mid-transfer: outputs clear immediately and asynchronously, contents clear, and the in-flight write is lost.

Test Plan:
1. WAIT_CYCLES=0. Write PADDR=0x12, PWDATA=0xDEADBEEF, PSTRB=4'hF, then read 0x12.
   - Both transfers: PREADY=1 in the first access cycle.
   - Read: PRDATA=0xDEADBEEF, PSLVERR=0.
2. Write 0x15=0xDABBCAFE with PSTRB=4'hF, then write 0x15=0x11223344 with PSTRB=4'b0011, then read 0x15.
   - Read: PRDATA=0xDABB3344.
3. Read PADDR=0x1A (26 >= DEPTH), then write 0x1A=0xFFFFFFFF.
   - Read: PSLVERR=1 with PREADY, PRDATA=0.
   - Write: PSLVERR=1.
   - Subsequent read of 0x12: PRDATA=0xDEADBEEF, PSLVERR=0 (valid storage unaffected).
4. WAIT_CYCLES=2. Write 0x03=0xCAFEF00D, then read it.
   - PREADY low for access cycles 1-2, high in cycle 3.
   - Read: PRDATA=0xCAFEF00D.
   - Back-to-back pair completes in 8 cycles.
5. WAIT_CYCLES=3. Begin a write to 0x04=0x12345678, drop PSEL after the first access cycle.
   - PREADY never asserts.
   - Subsequent read of 0x04: PRDATA=0x00000000.
6. Assert PRESETn=0 mid-edge-cycle during WAIT of a write to 0x05.
   - PREADY/PSLVERR/PRDATA go to 0 without waiting for a PCLK edge.
   - After release, reads of 0x05 and 0x12 return 0.
